// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline command controller: opcodes, FSM state
// encoding, strobe slots and per-opcode argument byte counts.
package pipeline_ctrl_pkg;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_WRITE_INSTR = 8'h01;
    localparam logic [7:0] OP_WRITE_REG   = 8'h02;
    localparam logic [7:0] OP_UPDATE_REG  = 8'h03;
    localparam logic [7:0] OP_ALLOC_DELAY = 8'h04;

    localparam int CNT_W = 8;

    localparam int STB_INSTR  = 0;
    localparam int STB_REG    = 1;
    localparam int STB_UPDATE = 2;
    localparam int STB_ALLOC  = 3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ARGS      = 2'd1,
        S_WAIT_PIPE = 2'd2,
        S_ISSUE     = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] arg_count(input logic [7:0] op,
                                                   input int instr_bytes,
                                                   input int data_bytes);
        case (op)
            OP_WRITE_INSTR: arg_count = CNT_W'(instr_bytes + 1);
            OP_WRITE_REG,
            OP_UPDATE_REG:  arg_count = CNT_W'(data_bytes + 2);
            OP_ALLOC_DELAY: arg_count = CNT_W'(data_bytes);
            default:        arg_count = '0;
        endcase
    endfunction

    function automatic logic [3:0] strobe_for(input logic [7:0] op);
        strobe_for = '0;
        case (op)
            OP_WRITE_INSTR: strobe_for[STB_INSTR]  = 1'b1;
            OP_WRITE_REG:   strobe_for[STB_REG]    = 1'b1;
            OP_UPDATE_REG:  strobe_for[STB_UPDATE] = 1'b1;
            OP_ALLOC_DELAY: strobe_for[STB_ALLOC]  = 1'b1;
            default:        strobe_for = '0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_arg_shifter.sv
// Argument collector: shifts accepted bytes in MSB-first and counts down the
// bytes still expected; last_o flags that the argument list is complete.
module cmd_arg_shifter
    import pipeline_ctrl_pkg::*;
#(
    parameter int SR_W = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [7:0]       byte_i,
    output logic             last_o,
    output logic [SR_W-1:0]  args_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SR_W-1:0]  sr_q, sr_d;

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (load_i) begin
            cnt_d = count_i;
            sr_d  = '0;
        end else if (shift_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
            sr_d  = {sr_q[SR_W-9:0], byte_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    assign last_o = (cnt_q == '0);
    assign args_o = sr_q;

endmodule

// File: rtl/pipeline_controller.sv
// Byte-stream command decoder that validates block/register commands, waits
// for an idle pipeline, then issues a single-cycle command strobe.
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int n_blocks          = 2,
    parameter int data_width        = 16,
    parameter int instr_width       = 32,
    parameter int reg_addr_width    = 4,
    parameter int n_block_registers = 16,
    localparam int BLK_W            = (n_blocks > 1) ? $clog2(n_blocks) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                in_byte,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      pipe_ready,
    output logic [BLK_W-1:0]          block_target,
    output logic [reg_addr_width-1:0] reg_target,
    output logic [instr_width-1:0]    instr_val,
    output logic [data_width-1:0]     ctrl_data,
    output logic                      instr_write,
    output logic                      reg_write,
    output logic                      reg_update,
    output logic                      alloc_sram_delay,
    output logic                      invalid_command,
    output logic                      busy
);

    localparam int DATA_BYTES  = data_width / 8;
    localparam int INSTR_BYTES = instr_width / 8;
    localparam int SR_BYTES    = (INSTR_BYTES + 1 > DATA_BYTES + 2) ? INSTR_BYTES + 1
                                                                     : DATA_BYTES + 2;
    localparam int SR_W        = 8 * SR_BYTES;

    state_e                    state_q, state_d;
    logic [7:0]                opcode_q, opcode_d;
    logic [BLK_W-1:0]          block_q, block_d;
    logic [reg_addr_width-1:0] regad_q, regad_d;
    logic [instr_width-1:0]    instr_q, instr_d;
    logic [data_width-1:0]     data_q, data_d;
    logic [3:0]                strobe_q, strobe_d;
    logic                      invalid_q, invalid_d;

    logic            load, shift, last, accept, cmd_bad;
    logic [SR_W-1:0] args;
    logic [7:0]      blk_byte, reg_byte;

    cmd_arg_shifter #(.SR_W(SR_W)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (shift),
        .count_i (arg_count(in_byte, INSTR_BYTES, DATA_BYTES)),
        .byte_i  (in_byte),
        .last_o  (last),
        .args_o  (args)
    );

    // The cycle after the final argument byte is spent validating, so bytes are held off.
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_ARGS) && !last);
    assign accept   = in_valid && in_ready;

    always_comb begin
        blk_byte = '0;
        reg_byte = '0;
        case (opcode_q)
            OP_WRITE_INSTR: blk_byte = args[instr_width +: 8];
            OP_WRITE_REG,
            OP_UPDATE_REG: begin
                blk_byte = args[data_width + 8 +: 8];
                reg_byte = args[data_width +: 8];
            end
            default: ;
        endcase
    end

    assign cmd_bad = ({24'd0, blk_byte} >= 32'(n_blocks)) ||
                     ({24'd0, reg_byte} >= 32'(n_block_registers));

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        block_d   = block_q;
        regad_d   = regad_q;
        instr_d   = instr_q;
        data_d    = data_q;
        strobe_d  = '0;
        invalid_d = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && (in_byte != OP_NOP)) begin
                    if (in_byte <= OP_ALLOC_DELAY) begin
                        opcode_d = in_byte;
                        load     = 1'b1;
                        state_d  = S_ARGS;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
            end
            S_ARGS: begin
                if (last) begin
                    if (cmd_bad) begin
                        invalid_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_WAIT_PIPE;
                        case (opcode_q)
                            OP_WRITE_INSTR: begin
                                block_d = blk_byte[BLK_W-1:0];
                                instr_d = args[instr_width-1:0];
                            end
                            OP_WRITE_REG,
                            OP_UPDATE_REG: begin
                                block_d = blk_byte[BLK_W-1:0];
                                regad_d = reg_byte[reg_addr_width-1:0];
                                data_d  = args[data_width-1:0];
                            end
                            OP_ALLOC_DELAY: data_d = args[data_width-1:0];
                            default: ;
                        endcase
                    end
                end else if (accept) begin
                    shift = 1'b1;
                end
            end
            S_WAIT_PIPE: begin
                if (pipe_ready) begin
                    strobe_d = strobe_for(opcode_q);
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            opcode_q  <= OP_NOP;
            block_q   <= '0;
            regad_q   <= '0;
            instr_q   <= '0;
            data_q    <= '0;
            strobe_q  <= '0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            block_q   <= block_d;
            regad_q   <= regad_d;
            instr_q   <= instr_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            invalid_q <= invalid_d;
        end
    end

    assign block_target     = block_q;
    assign reg_target       = regad_q;
    assign instr_val        = instr_q;
    assign ctrl_data        = data_q;
    assign instr_write      = strobe_q[STB_INSTR];
    assign reg_write        = strobe_q[STB_REG];
    assign reg_update       = strobe_q[STB_UPDATE];
    assign alloc_sram_delay = strobe_q[STB_ALLOC];
    assign invalid_command  = invalid_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: command byte sequences with
// hand-computed strobe timing and output field values.
module tb_pipeline_controller;

    logic        clk;
    logic        reset;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        pipe_ready;
    logic        block_target;
    logic [3:0]  reg_target;
    logic [31:0] instr_val;
    logic [15:0] ctrl_data;
    logic        instr_write, reg_write, reg_update, alloc_sram_delay;
    logic        invalid_command;
    logic        busy;

    int checks = 0;
    int errors = 0;

    pipeline_controller #(
        .n_blocks          (2),
        .data_width        (16),
        .instr_width       (32),
        .reg_addr_width    (4),
        .n_block_registers (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_byte          (in_byte),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .pipe_ready       (pipe_ready),
        .block_target     (block_target),
        .reg_target       (reg_target),
        .instr_val        (instr_val),
        .ctrl_data        (ctrl_data),
        .instr_write      (instr_write),
        .reg_write        (reg_write),
        .reg_update       (reg_update),
        .alloc_sram_delay (alloc_sram_delay),
        .invalid_command  (invalid_command),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe vector: {alloc, update, reg_write, instr_write}
    logic [3:0] strb;
    assign strb = {alloc_sram_delay, reg_update, reg_write, instr_write};

    int         nstrb = 0;
    int         wide_cnt = 0;
    int         overlap_cnt = 0;
    logic [3:0] prev_strb = 4'd0;
    logic [15:0] cap_data [0:15];
    logic [3:0]  cap_kind [0:15];

    always @(negedge clk) begin
        prev_strb <= strb;
        if ((strb & prev_strb) != 4'd0) wide_cnt <= wide_cnt + 1;
        if (($countones(strb) > 1) || (invalid_command && (strb != 4'd0)))
            overlap_cnt <= overlap_cnt + 1;
        if (strb != 4'd0) begin
            if (nstrb < 16) begin
                cap_data[nstrb[3:0]] <= ctrl_data;
                cap_kind[nstrb[3:0]] <= strb;
            end
            nstrb <= nstrb + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_byte  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    // Called right after the edge that accepted the final argument byte (e0).
    task automatic finish_cmd(input string tag, input logic [3:0] exp_strb);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_e0_strb"}, 32'(strb), 32'd0);
        chk({tag, "_e0_rdy"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_e1_strb"}, 32'(strb), 32'd0);
        @(negedge clk);
        chk({tag, "_e2_strb"}, 32'(strb), 32'(exp_strb));
        chk({tag, "_e2_inv"}, 32'(invalid_command), 32'd0);
        @(negedge clk);
        chk({tag, "_e3_strb"}, 32'(strb), 32'd0);
        chk({tag, "_e3_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_e3_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_byte    = 8'h00;
        pipe_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strb", 32'(strb), 32'd0);
        chk("rst_inv", 32'(invalid_command), 32'd0);
        chk("rst_blk", 32'(block_target), 32'd0);
        chk("rst_reg", 32'(reg_target), 32'd0);
        chk("rst_instr", instr_val, 32'd0);
        chk("rst_data", 32'(ctrl_data), 32'd0);
        reset = 1'b0;

        // WRITE_REG block 1 reg 5 data 0x1234
        send(8'h02); send(8'h01); send(8'h05); send(8'h12); send(8'h34);
        finish_cmd("wreg", 4'b0010);
        chk("wreg_blk", 32'(block_target), 32'd1);
        chk("wreg_reg", 32'(reg_target), 32'd5);
        chk("wreg_data", 32'(ctrl_data), 32'h1234);

        // WRITE_INSTR block 0, ctrl_data and reg_target untouched
        send(8'h01); send(8'h00); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        finish_cmd("winstr", 4'b0001);
        chk("winstr_val", instr_val, 32'hDEADBEEF);
        chk("winstr_blk", 32'(block_target), 32'd0);
        chk("winstr_data", 32'(ctrl_data), 32'h1234);
        chk("winstr_reg", 32'(reg_target), 32'd5);

        // UPDATE_REG stalled by pipe_ready low for 10 cycles
        pipe_ready = 1'b0;
        send(8'h03); send(8'h00); send(8'h02); send(8'hAB); send(8'hCD);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_strb", 32'(strb), 32'd0);
            chk("stall_rdy", 32'(in_ready), 32'd0);
        end
        chk("stall_busy", 32'(busy), 32'd1);
        pipe_ready = 1'b1;
        @(negedge clk);
        chk("upd_strb", 32'(strb), 32'b0100);
        @(negedge clk);
        chk("upd_strb_off", 32'(strb), 32'd0);
        chk("upd_rdy", 32'(in_ready), 32'd1);
        chk("upd_blk", 32'(block_target), 32'd0);
        chk("upd_reg", 32'(reg_target), 32'd2);
        chk("upd_data", 32'(ctrl_data), 32'hABCD);

        // Unknown opcode then NOP
        send(8'h7F);
        @(negedge clk);
        chk("badop_inv", 32'(invalid_command), 32'd1);
        chk("badop_rdy", 32'(in_ready), 32'd1);
        in_byte = 8'h00;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("nop_inv", 32'(invalid_command), 32'd0);
        chk("nop_busy", 32'(busy), 32'd0);
        chk("nop_strb", 32'(strb), 32'd0);

        // Block index out of range
        n0 = nstrb;
        send(8'h02); send(8'h02); send(8'h00); send(8'h00); send(8'h01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("badblk_inv0", 32'(invalid_command), 32'd0);
        @(negedge clk);
        chk("badblk_inv1", 32'(invalid_command), 32'd1);
        chk("badblk_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("badblk_inv2", 32'(invalid_command), 32'd0);

        // Register index at the limit (16)
        send(8'h02); send(8'h01); send(8'h10); send(8'h00); send(8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("badreg_inv", 32'(invalid_command), 32'd1);
        repeat (3) @(negedge clk);
        chk("bad_nostrb", 32'(nstrb - n0), 32'd0);
        chk("bad_blk", 32'(block_target), 32'd0);
        chk("bad_reg", 32'(reg_target), 32'd2);
        chk("bad_data", 32'(ctrl_data), 32'hABCD);

        // Reset mid-command
        n0 = nstrb;
        send(8'h02); send(8'h01);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rdy", 32'(in_ready), 32'd1);
        chk("midrst_data", 32'(ctrl_data), 32'd0);
        chk("midrst_instr", instr_val, 32'd0);
        repeat (4) @(negedge clk);
        chk("midrst_nostrb", 32'(nstrb - n0), 32'd0);

        // ALLOC_DELAY size 0x0040
        send(8'h04); send(8'h00); send(8'h40);
        finish_cmd("alloc", 4'b1000);
        chk("alloc_data", 32'(ctrl_data), 32'h0040);

        // Back-to-back with in_valid held high
        n0 = nstrb;
        send(8'h02); send(8'h00); send(8'h01); send(8'h00); send(8'h07);
        send(8'h03); send(8'h00); send(8'h01); send(8'h00); send(8'h08);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("b2b_count", 32'(nstrb - n0), 32'd2);
        if (nstrb - n0 >= 2 && n0 + 1 < 16) begin
            chk("b2b_kind0", 32'(cap_kind[n0[3:0]]), 32'b0010);
            chk("b2b_data0", 32'(cap_data[n0[3:0]]), 32'h0007);
            chk("b2b_kind1", 32'(cap_kind[4'(n0 + 1)]), 32'b0100);
            chk("b2b_data1", 32'(cap_data[4'(n0 + 1)]), 32'h0008);
        end
        chk("b2b_reg", 32'(reg_target), 32'd1);
        chk("b2b_blk", 32'(block_target), 32'd0);
        chk("strobe_width", 32'(wide_cnt), 32'd0);
        chk("strobe_overlap", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
